// File: rtl/fifo_arb_salida_pkg.sv
// Shared defaults, reset values and operation encoding for the output-side
// FIFOs that sit behind the 4-way arbiter.
package fifo_arb_salida_pkg;

    localparam int DATA_WIDTH_DEF = 6;   // 2-bit dest + 4-bit payload
    localparam int ADDR_WIDTH_DEF = 2;
    localparam int DEPTH_DEF      = 1 << ADDR_WIDTH_DEF;

    // Reset values shared with the arbiter and the sibling FIFOs
    localparam logic RST_VALID = 1'b0;
    localparam logic RST_ERROR = 1'b0;

    // What happened this cycle, from the accepted push/pop pair
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_t;

    function automatic fifo_op_t op_decode(input logic push_acc, input logic pop_acc);
        return fifo_op_t'({push_acc, pop_acc});
    endfunction

endpackage

// File: rtl/mem_fifo_2p.sv
// Dual-port register file: one write port, one synchronous read port.
// The array itself is never reset; only the read register is.
module mem_fifo_2p
    import fifo_arb_salida_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port; no reset so the array maps onto plain storage
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Read register; holds its value when no read is issued. A same-cycle
    // write to the read address returns the old word (read-before-write).
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fifo_arb_salida.sv
// Output-side FIFO behind the arbiter: pointers, occupancy count,
// watermark flags and a sticky overflow/underflow error.
module fifo_arb_salida
    import fifo_arb_salida_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    input  logic [ADDR_WIDTH:0]   umbral_alto,
    input  logic [ADDR_WIDTH:0]   umbral_bajo,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
);

    localparam int                  DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  push_acc, pop_acc, err_evt;
    fifo_op_t              op;

    // Status flags straight from the registered count and live watermarks
    always_comb begin
        empty        = (count == '0);
        full         = (count == DEPTH_CNT);
        almost_full  = (count >= umbral_alto);
        almost_empty = (count <= umbral_bajo);
    end

    // Acceptance: a pop frees a slot for a same-cycle push when full;
    // there is no bypass when empty, so that pop is rejected.
    always_comb begin
        pop_acc  = pop && !empty;
        push_acc = push && (!full || pop_acc);
        err_evt  = (push && !push_acc) || (pop && !pop_acc);
        op       = op_decode(push_acc, pop_acc);
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_acc)  rd_ptr <= rd_ptr + PTR_ONE;
            case (op)
                OP_PUSH: count <= count + CNT_ONE;
                OP_POP:  count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // valid_out marks a word popped on the previous edge; error is sticky
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            valid_out <= RST_VALID;
            error     <= RST_ERROR;
        end else begin
            valid_out <= pop_acc;
            if (err_evt) error <= 1'b1;
        end
    end

    mem_fifo_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .reset_L (reset_L),
        .wr_en   (push_acc),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (pop_acc),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_fifo_arb_salida.sv
// Directed bench for fifo_arb_salida: a vector table plus a few hand-built
// sequences for overflow and asynchronous reset.
module tb_fifo_arb_salida;

    logic       clk = 1'b0;
    logic       reset_L = 1'b1;
    logic       push = 1'b0;
    logic [5:0] data_in = '0;
    logic       pop = 1'b0;
    logic [2:0] umbral_alto = 3'd3;
    logic [2:0] umbral_bajo = 3'd1;
    logic [5:0] data_out;
    logic       valid_out, empty, full, almost_full, almost_empty, error;

    int total = 0;
    int bad   = 0;

    fifo_arb_salida dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .umbral_alto  (umbral_alto),
        .umbral_bajo  (umbral_bajo),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       push;
        logic [5:0] din;
        logic       pop;
        logic [2:0] ua;
        logic [2:0] ub;
        logic [5:0] e_do;
        logic       e_v, e_e, e_f, e_af, e_ae, e_err;
    } vec_t;

    function automatic vec_t mk(input logic p, input logic [5:0] d, input logic q,
                                input logic [2:0] ua, input logic [2:0] ub,
                                input logic [5:0] edo, input logic ev, input logic ee,
                                input logic ef, input logic eaf, input logic eae,
                                input logic eerr);
        vec_t v;
        v.push = p;   v.din = d;   v.pop = q;  v.ua = ua;  v.ub = ub;
        v.e_do = edo; v.e_v = ev;  v.e_e = ee; v.e_f = ef;
        v.e_af = eaf; v.e_ae = eae; v.e_err = eerr;
        return v;
    endfunction

    // Compare all outputs as one packed word {data_out,valid,empty,full,af,ae,error}
    task automatic chk(input string nm, input logic [5:0] edo, input logic ev,
                       input logic ee, input logic ef, input logic eaf,
                       input logic eae, input logic eerr);
        logic [11:0] act, exp;
        act = {data_out, valid_out, empty, full, almost_full, almost_empty, error};
        exp = {edo, ev, ee, ef, eaf, eae, eerr};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got do=%h v=%b e=%b f=%b af=%b ae=%b err=%b exp do=%h v=%b e=%b f=%b af=%b ae=%b err=%b",
                     nm, act[11:6], act[5], act[4], act[3], act[2], act[1], act[0],
                     exp[11:6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Drive one vector on the falling edge, check #1 after the rising edge
    task automatic run(input vec_t v, input string nm);
        @(negedge clk);
        push = v.push; data_in = v.din; pop = v.pop;
        umbral_alto = v.ua; umbral_bajo = v.ub;
        @(posedge clk);
        #1;
        chk(nm, v.e_do, v.e_v, v.e_e, v.e_f, v.e_af, v.e_ae, v.e_err);
    endtask

    vec_t tbl [24];

    initial begin
        //            push din  pop ua ub | do   v e f af ae err
        tbl[0]  = mk(0, 6'h00, 0, 3, 1,  6'h00, 0,1,0,0,1,0);
        tbl[1]  = mk(1, 6'h11, 0, 3, 1,  6'h00, 0,0,0,0,1,0);
        tbl[2]  = mk(1, 6'h22, 0, 3, 1,  6'h00, 0,0,0,0,0,0);
        tbl[3]  = mk(1, 6'h33, 0, 3, 1,  6'h00, 0,0,0,1,0,0);
        tbl[4]  = mk(1, 6'h04, 0, 3, 1,  6'h00, 0,0,1,1,0,0);
        tbl[5]  = mk(0, 6'h00, 1, 3, 1,  6'h11, 1,0,0,1,0,0);
        tbl[6]  = mk(0, 6'h00, 1, 3, 1,  6'h22, 1,0,0,0,0,0);
        tbl[7]  = mk(0, 6'h00, 1, 3, 1,  6'h33, 1,0,0,0,1,0);
        tbl[8]  = mk(0, 6'h00, 1, 3, 1,  6'h04, 1,1,0,0,1,0);
        tbl[9]  = mk(0, 6'h00, 0, 3, 1,  6'h04, 0,1,0,0,1,0);
        tbl[10] = mk(0, 6'h00, 0, 0, 0,  6'h04, 0,1,0,1,1,0);
        tbl[11] = mk(0, 6'h00, 0, 4, 0,  6'h04, 0,1,0,0,1,0);
        tbl[12] = mk(1, 6'h01, 0, 3, 1,  6'h04, 0,0,0,0,1,0);
        tbl[13] = mk(1, 6'h02, 0, 3, 1,  6'h04, 0,0,0,0,0,0);
        tbl[14] = mk(1, 6'h03, 0, 3, 1,  6'h04, 0,0,0,1,0,0);
        tbl[15] = mk(1, 6'h05, 0, 3, 1,  6'h04, 0,0,1,1,0,0);
        tbl[16] = mk(1, 6'h2A, 1, 3, 1,  6'h01, 1,0,1,1,0,0);
        tbl[17] = mk(0, 6'h00, 1, 3, 1,  6'h02, 1,0,0,1,0,0);
        tbl[18] = mk(0, 6'h00, 1, 3, 1,  6'h03, 1,0,0,0,0,0);
        tbl[19] = mk(0, 6'h00, 1, 3, 1,  6'h05, 1,0,0,0,1,0);
        tbl[20] = mk(0, 6'h00, 1, 3, 1,  6'h2A, 1,1,0,0,1,0);
        tbl[21] = mk(1, 6'h15, 1, 3, 1,  6'h2A, 0,0,0,0,1,1);
        tbl[22] = mk(0, 6'h00, 1, 3, 1,  6'h15, 1,1,0,0,1,1);
        tbl[23] = mk(0, 6'h00, 1, 3, 1,  6'h15, 0,1,0,0,1,1);

        // Asynchronous reset, checked before any clock edge
        #2 reset_L = 1'b0;
        #1 chk("reset", 6'h00, 0, 1, 0, 0, 1, 0);
        @(negedge clk);
        @(negedge clk);
        reset_L = 1'b1;

        for (int i = 0; i < 24; i++)
            run(tbl[i], $sformatf("vec%0d", i));

        // Reset mid-stream: FIFO holds a word and error is set
        run(mk(1, 6'h07, 0, 3, 1, 6'h15, 0,0,0,0,1,1), "pre_rst");
        @(negedge clk);
        push = 1'b0; pop = 1'b0;
        #2 reset_L = 1'b0;
        #1 chk("async_rst", 6'h00, 0, 1, 0, 0, 1, 0);
        @(negedge clk);
        reset_L = 1'b1;

        // Overflow: fill, then push 0x3F without pop
        run(mk(1, 6'h01, 0, 3, 1, 6'h00, 0,0,0,0,1,0), "ov_p1");
        run(mk(1, 6'h02, 0, 3, 1, 6'h00, 0,0,0,0,0,0), "ov_p2");
        run(mk(1, 6'h03, 0, 3, 1, 6'h00, 0,0,0,1,0,0), "ov_p3");
        run(mk(1, 6'h04, 0, 3, 1, 6'h00, 0,0,1,1,0,0), "ov_p4");
        run(mk(1, 6'h3F, 0, 3, 1, 6'h00, 0,0,1,1,0,1), "ov_push");
        run(mk(0, 6'h00, 1, 3, 1, 6'h01, 1,0,0,1,0,1), "ov_r1");
        run(mk(0, 6'h00, 1, 3, 1, 6'h02, 1,0,0,0,0,1), "ov_r2");
        run(mk(0, 6'h00, 1, 3, 1, 6'h03, 1,0,0,0,1,1), "ov_r3");
        run(mk(0, 6'h00, 1, 3, 1, 6'h04, 1,1,0,0,1,1), "ov_r4");
        run(mk(0, 6'h00, 0, 3, 1, 6'h04, 0,1,0,0,1,1), "ov_idle1");
        run(mk(0, 6'h00, 0, 3, 1, 6'h04, 0,1,0,0,1,1), "ov_idle2");

        // Only reset clears the sticky error
        @(negedge clk);
        #2 reset_L = 1'b0;
        #1 chk("err_clear", 6'h00, 0, 1, 0, 0, 1, 0);
        @(negedge clk);
        reset_L = 1'b1;
        run(mk(0, 6'h00, 0, 3, 1, 6'h00, 0,1,0,0,1,0), "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
